// File: rtl/printer_pkg.sv
// Shared types and constants for the printer-side receive buffer.
package printer_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACK, STALL} hs_state_t;
  typedef enum logic [1:0] {P_IDLE, P_PRINT, P_FEED} pr_state_t;

  localparam logic [DATA_W-1:0] LF_CHAR = 8'h0A;

endpackage

// File: rtl/printer_fifo.sv
// Small power-of-two FIFO; extra pointer MSB separates full from empty.
module printer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [WIDTH-1:0]         o_dout_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PTR_W'(1);
      if (i_pop)  r_rp <= r_rp + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp[ADDR_W-1:0]] <= i_din;
  end

  assign o_empty_c = (r_wp == r_rp);
  assign o_full_c  = (r_wp[PTR_W-1] != r_rp[PTR_W-1]) &&
                     (r_wp[ADDR_W-1:0] == r_rp[ADDR_W-1:0]);
  assign o_dout_c  = r_mem[r_rp[ADDR_W-1:0]];
  assign o_count_c = r_wp - r_rp;

endmodule

// File: rtl/printer_buffer.sv
// Printer receiver: TR/PD/RDY handshake into a FIFO, drained by a timed print engine.
module printer_buffer
  import printer_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PRINT_CYCLES = 13,
  parameter int unsigned LF_EXTRA     = 8,
  parameter int unsigned ACK_MIN      = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              TR,
  input  logic [DATA_W-1:0] PD,
  output logic              RDY,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic [15:0]       char_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_MAX = (PRINT_CYCLES > LF_EXTRA) ? PRINT_CYCLES : LF_EXTRA;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ACK_W   = $clog2(ACK_MIN + 1);
  localparam int unsigned PR_LOAD = PRINT_CYCLES - 1;
  localparam int unsigned LF_LOAD = (LF_EXTRA > 0) ? LF_EXTRA - 1 : 0;
  localparam bit          LF_EN   = (LF_EXTRA != 0);

  hs_state_t         r_hs_state, w_hs_next;
  logic [ACK_W-1:0]  r_ack_cnt, w_ack_cnt_next;
  logic              w_ack_done;
  logic              w_push;

  pr_state_t         r_pr_state, w_pr_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [DATA_W-1:0] r_hold, w_hold_next;
  logic              w_pop;

  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_dv, w_dv_next;
  logic [15:0]       r_char_cnt, w_char_cnt_next;
  logic              r_busy, r_rdy;

  logic              w_full, w_empty;
  logic [DATA_W-1:0] w_fifo_dout;
  logic [PTR_W-1:0]  w_count, w_count_next;

  printer_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (RSTn),
    .i_push    (w_push),
    .i_din     (PD),
    .i_pop     (w_pop),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_dout_c  (w_fifo_dout),
    .o_count_c (w_count)
  );

  // Handshake: capture only from IDLE, which is entered only while the FIFO has room.
  always_comb begin
    w_hs_next      = r_hs_state;
    w_ack_cnt_next = r_ack_cnt;
    w_push         = 1'b0;
    w_ack_done     = (r_ack_cnt >= ACK_W'(ACK_MIN - 1));
    case (r_hs_state)
      IDLE: begin
        w_ack_cnt_next = '0;
        if (TR) begin
          w_push    = 1'b1;
          w_hs_next = ACK;
        end
      end
      ACK: begin
        if (!TR && w_ack_done) w_hs_next = w_full ? STALL : IDLE;
        else if (!w_ack_done)  w_ack_cnt_next = r_ack_cnt + ACK_W'(1);
      end
      STALL: begin
        if (!w_full) w_hs_next = IDLE;
      end
      default: w_hs_next = IDLE;
    endcase
  end

  // Print engine: pop, count down the print time, strobe, optional line-feed pause.
  always_comb begin
    w_pr_next       = r_pr_state;
    w_cnt_next      = r_cnt;
    w_hold_next     = r_hold;
    w_pop           = 1'b0;
    w_data_next     = r_data;
    w_dv_next       = 1'b0;
    w_char_cnt_next = r_char_cnt;
    case (r_pr_state)
      P_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_hold_next = w_fifo_dout;
          w_cnt_next  = CNT_W'(PR_LOAD);
          w_pr_next   = P_PRINT;
        end
      end
      P_PRINT: begin
        if (r_cnt == '0) begin
          w_data_next     = r_hold;
          w_dv_next       = 1'b1;
          w_char_cnt_next = r_char_cnt + 16'd1;
          if (LF_EN && (r_hold == LF_CHAR)) begin
            w_cnt_next = CNT_W'(LF_LOAD);
            w_pr_next  = P_FEED;
          end else begin
            w_pr_next = P_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      P_FEED: begin
        if (r_cnt == '0) w_pr_next = P_IDLE;
        else             w_cnt_next = r_cnt - CNT_W'(1);
      end
      default: w_pr_next = P_IDLE;
    endcase
  end

  // Registered busy mirrors the post-edge FIFO occupancy and engine state.
  assign w_count_next = w_count + PTR_W'(w_push) - PTR_W'(w_pop);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_hs_state <= IDLE;
      r_ack_cnt  <= '0;
      r_pr_state <= P_IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_char_cnt <= '0;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b1;
    end else begin
      r_hs_state <= w_hs_next;
      r_ack_cnt  <= w_ack_cnt_next;
      r_pr_state <= w_pr_next;
      r_cnt      <= w_cnt_next;
      r_hold     <= w_hold_next;
      r_data     <= w_data_next;
      r_dv       <= w_dv_next;
      r_char_cnt <= w_char_cnt_next;
      r_busy     <= (w_count_next != '0) || (w_pr_next != P_IDLE);
      r_rdy      <= (w_hs_next == IDLE);
    end
  end

  assign RDY        = r_rdy;
  assign data       = r_data;
  assign data_valid = r_dv;
  assign busy       = r_busy;
  assign char_count = r_char_cnt;

endmodule

// File: doc/printer_buffer.md
Name: printer_buffer

Overview:
Printer-side receiver that sits directly downstream of the POC. It accepts bytes over the TR/PD/RDY handshake and queues them in a small FIFO. A print engine drains the FIFO at a fixed per-character print time and presents each printed character on data with a one-cycle strobe. RDY is held low while the FIFO is full, so a slow print rate back-pressures the POC.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
PRINT_CYCLES, 13, cycles to print one character; at least 1.
LF_EXTRA, 8, extra cycles added after printing 8'h0A (line feed).
ACK_MIN, 2, minimum number of cycles RDY stays low per accepted byte; at least 1.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RSTn  in  1  reset; synchronous, active-low.
TR  in  1  transfer request from POC; PD is valid while TR=1.
PD  in  8  parallel data from POC.
RDY  out  1  1 = ready to accept a byte.
data  out  8  last printed character.
data_valid  out  1  one-cycle pulse when data updates.
busy  out  1  1 while the FIFO is non-empty or a print is in progress.
char_count  out  16  total characters printed since reset; wraps modulo 2^16.

Behaviour:
- Reset (RSTn=0 sampled at posedge):
  - RDY=1, data=8'h00, data_valid=0, busy=0, char_count=0.
  - FIFO emptied; both FSMs go to their idle state.
  - Reset mid-print or mid-handshake discards all queued and in-flight bytes.
- Handshake FSM, states IDLE, ACK, STALL:
  - IDLE: RDY=1. When TR=1, push PD into the FIFO that cycle and go to ACK; RDY=0 from the next cycle.
  - ACK: RDY=0. Leave only when TR=0 AND at least ACK_MIN cycles have elapsed in ACK.
    - FIFO not full: go to IDLE.
    - FIFO full: go to STALL.
  - STALL: RDY=0. Go to IDLE on the first cycle the FIFO is not full.
  - IDLE is entered only with the FIFO not full, so a push is never lost. No overflow path exists.
  - TR held high indefinitely keeps the FSM in ACK. No second byte is captured until the FSM returns to IDLE and sees TR=1 again.
  - Per byte, the POC sees RDY go 1 -> 0 -> 1, at least ACK_MIN cycles low.
- Print FSM, states P_IDLE, P_PRINT, P_FEED:
  - P_IDLE: if the FIFO is non-empty, pop the head into a holding register, load the counter with PRINT_CYCLES-1, go to P_PRINT.
  - P_PRINT: count down. At 0:
    - data <= held byte, data_valid=1 for exactly that cycle, char_count increments.
    - If the byte is 8'h0A and LF_EXTRA>0, load LF_EXTRA-1 and go to P_FEED; otherwise go to P_IDLE.
  - P_FEED: count down; at 0 go to P_IDLE.
  - Latency, byte pushed into an empty FIFO with the engine idle: pop 1 cycle after the push, data_valid PRINT_CYCLES cycles after the pop.
  - Back-to-back characters: data_valid pulses spaced exactly PRINT_CYCLES+1 apart (no LF).
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits; full and empty are derived from the MSB compare.
  - Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
  - A push while full cannot occur by construction; the bench checks this with an assertion.
- busy = FIFO non-empty OR print FSM not in P_IDLE.
- All outputs are registered; no combinational path from TR or PD to RDY.

Decomposition:
- Shared package printer_pkg holds:
  - enum hs_state_t {IDLE, ACK, STALL}.
  - enum pr_state_t {P_IDLE, P_PRINT, P_FEED}.
  - Constant LF_CHAR = 8'h0A.
- One sub-module: printer_fifo (parameter DEPTH, width 8; push/pop/full/empty/dout). Instantiated once.
- Both FSMs and the counters live in printer_buffer.

Test Plan:
1. Reset then one byte, TR=1 for 1 cycle with PD=8'h41 -> RDY low for 2 cycles then high; data=8'h41 with data_valid 14 cycles after the push; char_count=1.
2. Five bytes 8'h01..8'h05 sent as fast as RDY allows, DEPTH=4 -> FSM enters STALL after the 5th push with RDY held 0 until the first pop; all 5 printed in order, pulses 14 cycles apart.
3. Byte 8'h0A then 8'h42 -> gap between the two data_valid pulses is 14+8=22 cycles.
4. TR held high 20 cycles with PD=8'h55 -> exactly one byte captured; RDY stays 0 until TR drops, then returns to 1 after at least ACK_MIN cycles.
5. RSTn=0 for 1 cycle during P_PRINT with 3 bytes queued -> next cycle RDY=1, busy=0, char_count=0, no further data_valid.
6. Occupancy at 2 with a push and pop landing in the same cycle -> occupancy remains 2; output order preserved.
